// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : systolic_pkg
// Description : Shared definitions for the systolic tile datapath: sequencer
//               state encoding, default array/reduction dimensions shared
//               with the PE array and operand buffers, and a width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package systolic_pkg;

  // Default array dimension and reduction depth used across the tile.
  localparam int DEFAULT_N = 4;
  localparam int DEFAULT_K = 8;

  // Tile sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

  // Counter width for values 0..x-1, never narrower than one bit.
  function automatic int clog2_min1(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage
`default_nettype wire

// File: rtl/skew_lane_mask.sv
`default_nettype none
// ============================================================================
// Module      : skew_lane_mask
// Description : Combinational diagonal-skew lane mask. Lane i is active on
//               feed cycle c when it presents operand k = c - i, i.e. when
//               i <= c < i + K.
// Ports       : feed_cnt  [CW-1:0] in  - feed cycle index c
//               lane_mask [N-1:0]  out - unregistered per-lane activity mask
// Revision    : 1.0 - initial release
// ============================================================================
module skew_lane_mask
  import systolic_pkg::*;
#(
  parameter int N  = DEFAULT_N,
  parameter int K  = DEFAULT_K,
  parameter int CW = 4
) (
  input  logic [CW-1:0] feed_cnt,
  output logic [N-1:0]  lane_mask
);

  // Compare in 32 bits so that i + K never truncates against a narrow counter.
  logic [31:0] cnt_ext;
  assign cnt_ext = 32'(feed_cnt);

  for (genvar i = 0; i < N; i++) begin : g_lane
    if (i == 0) begin : g_first
      // Lower bound is trivially met for lane 0.
      assign lane_mask[i] = (cnt_ext < 32'(K));
    end else begin : g_rest
      assign lane_mask[i] = (cnt_ext >= 32'(i)) && (cnt_ext < 32'(i + K));
    end
  end

endmodule
`default_nettype wire

// File: rtl/systolic_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : systolic_tile_sequencer
// Description : Sequences one output-stationary N x N systolic tile:
//               accumulator clear, skewed operand feed over K+2N-2 cycles,
//               then a row-by-row valid/ready result drain and a done pulse.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               start            - begin a tile (sampled only in IDLE)
//               feed_stall       - operand buffers not ready, freezes feed
//               drain_ready      - output writer accepts a result row
//               busy             - high in every state except IDLE
//               acc_clr          - one-cycle accumulator clear pulse
//               feed_cnt [CW]    - global feed cycle index
//               lane_en  [N]     - per-lane operand-present enables
//               drain_valid      - result row presented
//               drain_row [RW]   - index of the presented row
//               done             - one-cycle completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_tile_sequencer
  import systolic_pkg::*;
#(
  parameter  int N        = DEFAULT_N,
  parameter  int K        = DEFAULT_K,
  localparam int FEED_LEN = K + 2 * N - 2,
  localparam int CW       = clog2_min1(FEED_LEN),
  localparam int RW       = clog2_min1(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          feed_stall,
  input  logic          drain_ready,
  output logic          busy,
  output logic          acc_clr,
  output logic [CW-1:0] feed_cnt,
  output logic [N-1:0]  lane_en,
  output logic          drain_valid,
  output logic [RW-1:0] drain_row,
  output logic          done
);

  localparam logic [CW-1:0] LAST_CNT = CW'(FEED_LEN - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

  seq_state_t    state_q, state_d;
  logic [CW-1:0] feed_cnt_q, feed_cnt_d;
  logic [RW-1:0] drain_row_q, drain_row_d;
  logic [N-1:0]  lane_en_q, lane_en_d;
  logic          busy_q, busy_d;
  logic          acc_clr_q, acc_clr_d;
  logic          drain_valid_q, drain_valid_d;
  logic          done_q, done_d;
  logic [N-1:0]  lane_mask;

  // Mask for the feed index that will be presented next cycle.
  skew_lane_mask #(
    .N  (N),
    .K  (K),
    .CW (CW)
  ) u_skew_lane_mask (
    .feed_cnt  (feed_cnt_d),
    .lane_mask (lane_mask)
  );

  // Next-state and counter updates.
  always_comb begin
    state_d     = state_q;
    feed_cnt_d  = feed_cnt_q;
    drain_row_d = drain_row_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        state_d    = ST_FEED;
        feed_cnt_d = '0;
      end
      ST_FEED: begin
        if (!feed_stall) begin
          if (feed_cnt_q == LAST_CNT) begin
            state_d     = ST_DRAIN;
            drain_row_d = '0;
          end else begin
            feed_cnt_d = feed_cnt_q + CW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (drain_ready) begin
          if (drain_row_q == LAST_ROW) begin
            state_d = ST_DONE;
          end else begin
            drain_row_d = drain_row_q + RW'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Registered outputs are decoded from the next state so that each output
  // lines up with the state it describes. A stalled feed cycle keeps
  // feed_cnt and blanks lane_en for as long as the index is being held, so
  // each feed index drives its lanes exactly once.
  always_comb begin
    busy_d        = (state_d != ST_IDLE);
    acc_clr_d     = (state_d == ST_CLEAR);
    drain_valid_d = (state_d == ST_DRAIN);
    done_d        = (state_d == ST_DONE);
    lane_en_d     = '0;
    if ((state_d == ST_FEED) && !((state_q == ST_FEED) && feed_stall)) begin
      lane_en_d = lane_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      feed_cnt_q    <= '0;
      drain_row_q   <= '0;
      lane_en_q     <= '0;
      busy_q        <= 1'b0;
      acc_clr_q     <= 1'b0;
      drain_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      feed_cnt_q    <= feed_cnt_d;
      drain_row_q   <= drain_row_d;
      lane_en_q     <= lane_en_d;
      busy_q        <= busy_d;
      acc_clr_q     <= acc_clr_d;
      drain_valid_q <= drain_valid_d;
      done_q        <= done_d;
    end
  end

  assign busy        = busy_q;
  assign acc_clr     = acc_clr_q;
  assign feed_cnt    = feed_cnt_q;
  assign lane_en     = lane_en_q;
  assign drain_valid = drain_valid_q;
  assign drain_row   = drain_row_q;
  assign done        = done_q;

endmodule
`default_nettype wire
